multicycle_controller: RTL
==========================

# multicycle_controller

Control unit for the multicycle RISC-V core. It sequences the shared-memory datapath one instruction at a time through a Moore state machine, and it drives every datapath enable and multiplexer select. It sits beside the datapath inside the multicycle top level and replaces the single-cycle main decoder. It supports lw, sw, R-type (add, sub, and, or, slt), I-type ALU (addi, andi, ori, slti), beq and jal.

## Interface
Parameters: none.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clock clk
- op  in  7  instruction opcode (Instr[6:0] from instruction register)
- funct3  in  3  Instr[14:12]
- funct7b5  in  1  Instr[30]
- zero  in  1  ALU zero flag
- pc_write  out  1  PC register enable
- adr_src  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_write  out  1  data memory write enable
- ir_write  out  1  instruction register and OldPC enable
- result_src  out  2  00 = ALUOut, 01 = Data register, 10 = ALUResult
- alu_src_a  out  2  00 = PC, 01 = OldPC, 10 = register A
- alu_src_b  out  2  00 = register WriteData, 01 = ImmExt, 10 = constant 4
- alu_control  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- reg_write  out  1  register file write enable
- imm_src  out  2  00 = I, 01 = S, 10 = B, 11 = J
- instr_done  out  1  one-cycle pulse in the final state of each instruction
- illegal  out  1  one-cycle pulse in DECODE when op is unsupported

## Operation
- The state register is the only sequential element. Outputs are decoded from the state; alu_control, imm_src and pc_write also depend on the inputs. Any output not listed for a state is 0. ALUOp is internal: 00 add, 01 sub, 10 funct.
- FETCH: adr_src=0, ir_write=1, alu_src_a=00, alu_src_b=10, ALUOp=00, result_src=10, PCUpdate=1. Next state is DECODE.
- DECODE: alu_src_a=01, alu_src_b=01, ALUOp=00. Next state by op:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECUTER
  - 0010011 → EXECUTEI
  - 1100011 → BEQ
  - 1101111 → JAL
  - any other op → FETCH, with illegal=1 and instr_done=1
- MEMADR: alu_src_a=10, alu_src_b=01, ALUOp=00. Next state is MEMREAD if op[5]=0, otherwise MEMWRITE.
- MEMREAD: result_src=00, adr_src=1. Next state is MEMWB.
- MEMWB: result_src=01, reg_write=1, instr_done=1. Next state is FETCH.
- MEMWRITE: result_src=00, adr_src=1, mem_write=1, instr_done=1. Next state is FETCH.
- EXECUTER: alu_src_a=10, alu_src_b=00, ALUOp=10. Next state is ALUWB.
- EXECUTEI: alu_src_a=10, alu_src_b=01, ALUOp=10. Next state is ALUWB.
- JAL: alu_src_a=01, alu_src_b=10, ALUOp=00, result_src=00, PCUpdate=1. Next state is ALUWB.
- ALUWB: result_src=00, reg_write=1, instr_done=1. Next state is FETCH.
- BEQ: alu_src_a=10, alu_src_b=00, ALUOp=01, result_src=00, Branch=1, instr_done=1. Next state is FETCH.
- pc_write = PCUpdate | (Branch & zero).
- ALU decoder:
  - ALUOp 00 → 000; ALUOp 01 → 001.
  - ALUOp 10, funct3 000: 001 if {op[5], funct7b5} = 11, otherwise 000.
  - ALUOp 10, funct3 010 → 101; 110 → 011; 111 → 010; any other funct3 → 000.
- imm_src from op, in every state: 0100011 → 01; 1100011 → 10; 1101111 → 11; otherwise 00.

## Timing
- Reset value: state = FETCH.
- While reset is high, pc_write, ir_write, mem_write, reg_write, instr_done and illegal are forced to 0 combinationally. The select outputs show their FETCH values.
- After reset deasserts, the first rising edge with the FETCH enables active performs the fetch.
- Cycles per instruction, FETCH to FETCH: lw 5, sw 4, R-type 4, I-type 4, jal 4, beq 3, illegal 2.
- Instructions are counted on instr_done: exactly one pulse per instruction, in its last cycle.
- beq not taken: pc_write stays 0 in BEQ; the PC keeps the PC+4 written during FETCH.
- zero is sampled combinationally in BEQ only. A change of zero in any other state must not affect pc_write.
- Reset asserted mid-instruction, in any state: state returns to FETCH immediately and asynchronously. No partial mem_write or reg_write is issued after the reset edge.
- op changes outside FETCH are not expected, because the instruction register holds op stable. The controller decodes whatever op is present at each edge.

## Test plan
- lw x5, 4(x0) (op 0000011): states FETCH, DECODE, MEMADR, MEMREAD, MEMWB. reg_write=1 and result_src=01 only in cycle 5; instr_done pulses in cycle 5.
- sw (op 0100011): mem_write=1 with adr_src=1 only in cycle 4; imm_src=01 throughout; reg_write never asserted.
- R-type sub (funct3 000, funct7b5=1): alu_control=001 in EXECUTER, then reg_write=1 in ALUWB. Repeat with funct7b5=0: alu_control=000. Repeat with funct3 110: alu_control=011.
- beq with zero=1: pc_write=1 in cycle 3. With zero=0: pc_write=0 in cycle 3. Both cases return to FETCH with a 3-cycle instruction.
- jal: pc_write=1 in the JAL state, then reg_write=1 in ALUWB; imm_src=11.
- Unsupported op 0000000: illegal=1 and instr_done=1 in DECODE, then back to FETCH. Separately, assert reset during MEMREAD: all enables drop to 0 immediately and state is FETCH after reset releases.

Source files
------------

// File: rtl/multicycle_controller.sv
// Moore control unit for the multicycle RISC-V core: sequences one instruction
// at a time and drives every datapath enable and multiplexer select.
module multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic       reg_write,
  output logic [1:0] imm_src,
  output logic       instr_done,
  output logic       illegal
);

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECUTER,
    S_EXECUTEI,
    S_JAL,
    S_ALUWB,
    S_BEQ
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  state_t     state_reg, state_next;
  logic [1:0] alu_op;
  logic       pc_update;
  logic       branch;
  logic       mem_write_raw;
  logic       ir_write_raw;
  logic       reg_write_raw;
  logic       instr_done_raw;
  logic       illegal_raw;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= S_FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    adr_src        = 1'b0;
    result_src     = 2'b00;
    alu_src_a      = 2'b00;
    alu_src_b      = 2'b00;
    alu_op         = ALU_OP_ADD;
    pc_update      = 1'b0;
    branch         = 1'b0;
    mem_write_raw  = 1'b0;
    ir_write_raw   = 1'b0;
    reg_write_raw  = 1'b0;
    instr_done_raw = 1'b0;
    illegal_raw    = 1'b0;

    case (state_reg)
      S_FETCH: begin
        ir_write_raw = 1'b1;
        alu_src_b    = 2'b10;
        result_src   = 2'b10;
        pc_update    = 1'b1;
        state_next   = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_R:         state_next = S_EXECUTER;
          OP_I:         state_next = S_EXECUTEI;
          OP_BEQ:       state_next = S_BEQ;
          OP_JAL:       state_next = S_JAL;
          default: begin
            illegal_raw    = 1'b1;
            instr_done_raw = 1'b1;
            state_next     = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        state_next = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src    = 1'b1;
        state_next = S_MEMWB;
      end
      S_MEMWB: begin
        result_src     = 2'b01;
        reg_write_raw  = 1'b1;
        instr_done_raw = 1'b1;
        state_next     = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src        = 1'b1;
        mem_write_raw  = 1'b1;
        instr_done_raw = 1'b1;
        state_next     = S_FETCH;
      end
      S_EXECUTER: begin
        alu_src_a  = 2'b10;
        alu_op     = ALU_OP_FUNCT;
        state_next = S_ALUWB;
      end
      S_EXECUTEI: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        alu_op     = ALU_OP_FUNCT;
        state_next = S_ALUWB;
      end
      S_JAL: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        pc_update  = 1'b1;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_raw  = 1'b1;
        instr_done_raw = 1'b1;
        state_next     = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a      = 2'b10;
        alu_op         = ALU_OP_SUB;
        branch         = 1'b1;
        instr_done_raw = 1'b1;
        state_next     = S_FETCH;
      end
      default: state_next = S_FETCH;
    endcase
  end

  // Subtract only for R-type (op[5]=1) with funct7b5 set; I-type ignores funct7b5.
  always_comb begin
    alu_control = 3'b000;
    case (alu_op)
      ALU_OP_SUB: alu_control = 3'b001;
      ALU_OP_FUNCT: begin
        case (funct3)
          3'b000:  alu_control = ({op[5], funct7b5} == 2'b11) ? 3'b001 : 3'b000;
          3'b010:  alu_control = 3'b101;
          3'b110:  alu_control = 3'b011;
          3'b111:  alu_control = 3'b010;
          default: alu_control = 3'b000;
        endcase
      end
      default: alu_control = 3'b000;
    endcase
  end

  always_comb begin
    case (op)
      OP_SW:   imm_src = 2'b01;
      OP_BEQ:  imm_src = 2'b10;
      OP_JAL:  imm_src = 2'b11;
      default: imm_src = 2'b00;
    endcase
  end

  // Enables are gated by reset so nothing is written while reset is held.
  assign pc_write   = ~reset & (pc_update | (branch & zero));
  assign mem_write  = ~reset & mem_write_raw;
  assign ir_write   = ~reset & ir_write_raw;
  assign reg_write  = ~reset & reg_write_raw;
  assign instr_done = ~reset & instr_done_raw;
  assign illegal    = ~reset & illegal_raw;

endmodule
